// File: rtl/mining_pkg.sv
// Shared types and helpers for the mining job controller: FSM states, job
// geometry and the hash bit-reversal used for target comparison.
package mining_pkg;

    localparam int HDR_BITS  = 608;
    localparam int TGT_BITS  = 256;
    localparam int JOB_WORDS = 27;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_REPORT
    } state_t;

    // The core emits its hash LSB-first relative to the target's numeric order.
    function automatic logic [TGT_BITS-1:0] bit_reverse(input logic [TGT_BITS-1:0] value);
        logic [TGT_BITS-1:0] result;
        result = '0;
        for (int b = 0; b < TGT_BITS; b++) begin
            result[TGT_BITS-1-b] = value[b];
        end
        return result;
    endfunction

endpackage

// File: rtl/job_loader.sv
// Accepts 32-bit job words, shifting them MSW-first into the job register and
// flagging the final word so the controller can latch target and budget.
module job_loader #(
    parameter int HDR_WORDS = 19,
    parameter int TGT_WORDS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   job_valid,
    input  logic [31:0]            job_data,
    output logic                   job_ready,
    output logic                   accept,
    output logic                   last_word,
    output logic [32*HDR_WORDS-1:0] header,
    output logic [32*TGT_WORDS-1:0] target_next
);

    localparam int WORDS = HDR_WORDS + TGT_WORDS;
    localparam int JOB_W = 32 * WORDS;
    localparam int CNT_W = $clog2(WORDS);

    logic [JOB_W-1:0] job_reg;
    logic [JOB_W-1:0] shifted;
    logic [CNT_W-1:0] word_count;

    assign job_ready   = enable;
    assign accept      = job_valid && enable && !clear;
    assign last_word   = accept && (word_count == CNT_W'(WORDS - 1));
    assign shifted     = {job_reg[JOB_W-33:0], job_data};
    assign header      = job_reg[JOB_W-1 -: 32*HDR_WORDS];
    assign target_next = shifted[32*TGT_WORDS-1:0];

    // A clear drops any word offered in the same cycle so a cancelled job leaves no residue in the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            job_reg    <= '0;
            word_count <= '0;
        end else if (clear) begin
            word_count <= '0;
        end else if (accept) begin
            job_reg    <= shifted;
            word_count <= last_word ? '0 : word_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mining_job_controller.sv
// Sequences one mining job: load header/target, pulse the core reset, run the
// core against a cycle budget, and hold the best result until it is consumed.
module mining_job_controller #(
    parameter int WORDS_HDR = 19,
    parameter int WORDS_TGT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [31:0]            job_data,
    input  logic [31:0]            max_cycles,
    input  logic                   abort,
    output logic                   core_enable,
    output logic                   core_rst,
    output logic [32*WORDS_HDR-1:0] block_without_nonce,
    input  logic [255:0]           best_hash,
    input  logic [31:0]            best_hash_nonce,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_found,
    output logic [255:0]           res_hash,
    output logic [31:0]            res_nonce
);

    import mining_pkg::*;

    localparam int TGT_W = 32 * WORDS_TGT;

    state_t state;
    state_t next_state;

    logic             loader_enable;
    logic             abort_active;
    logic             accept;
    logic             last_word;
    logic [TGT_W-1:0] target_next;
    logic [TGT_W-1:0] target;
    logic [31:0]      budget;
    logic [31:0]      cycle_count;
    logic [255:0]     compare_value;
    logic             hit;
    logic             budget_end;
    logic             latch_result;

    assign loader_enable = (state == ST_IDLE) || (state == ST_LOAD);
    assign abort_active  = abort && ((state == ST_LOAD) || (state == ST_START) || (state == ST_RUN));
    assign compare_value = bit_reverse(best_hash);
    assign hit           = compare_value < target;
    assign budget_end    = cycle_count == budget;

    job_loader #(
        .HDR_WORDS (WORDS_HDR),
        .TGT_WORDS (WORDS_TGT)
    ) u_loader (
        .clk         (clk),
        .rst         (rst),
        .enable      (loader_enable),
        .clear       (abort_active),
        .job_valid   (job_valid),
        .job_data    (job_data),
        .job_ready   (job_ready),
        .accept      (accept),
        .last_word   (last_word),
        .header      (block_without_nonce),
        .target_next (target_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            target      <= '0;
            budget      <= '0;
            cycle_count <= '0;
            res_found   <= 1'b0;
            res_hash    <= '0;
            res_nonce   <= '0;
        end else begin
            state <= next_state;
            if (last_word) begin
                target <= target_next;
                budget <= max_cycles;
            end
            if (state == ST_START) begin
                cycle_count <= '0;
            end else if (state == ST_RUN && !abort_active) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (latch_result) begin
                res_found <= hit;
                res_hash  <= best_hash;
                res_nonce <= best_hash_nonce;
            end
        end
    end

    // A hit wins over budget exhaustion since both simply latch with res_found = hit.
    always_comb begin
        next_state   = state;
        core_enable  = 1'b0;
        core_rst     = 1'b0;
        res_valid    = 1'b0;
        latch_result = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (abort_active)   next_state = ST_IDLE;
                else if (last_word) next_state = ST_START;
            end
            ST_START: begin
                core_enable = 1'b1;
                core_rst    = 1'b1;
                next_state  = abort_active ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                core_enable = 1'b1;
                if (abort_active) begin
                    next_state = ST_IDLE;
                end else if (hit || budget_end) begin
                    latch_result = 1'b1;
                    next_state   = ST_REPORT;
                end
            end
            ST_REPORT: begin
                res_valid = 1'b1;
                if (res_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mining_job_controller.sv
// Scoreboard bench for mining_job_controller: stimulus pushes expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_mining_job_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_valid;
    logic         job_ready;
    logic [31:0]  job_data;
    logic [31:0]  max_cycles;
    logic         abort;
    logic         core_enable;
    logic         core_rst;
    logic [607:0] block_without_nonce;
    logic [255:0] best_hash;
    logic [31:0]  best_hash_nonce;
    logic         res_valid;
    logic         res_ready;
    logic         res_found;
    logic [255:0] res_hash;
    logic [31:0]  res_nonce;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        logic         found;
        logic [255:0] hash;
        logic [31:0]  nonce;
    } result_t;

    result_t expected_q[$];

    localparam logic [255:0] ALL_ONES = {256{1'b1}};
    localparam logic [255:0] H42      = 256'hDEADBEEF_00000000_11111111_22222222_33333333_44444444_55555555_66666666;
    localparam logic [255:0] H43      = 256'h0123_4567_89AB_CDEF;
    localparam logic [255:0] H45      = 256'hCAFE;
    localparam logic [255:0] H46      = 256'h7777;
    localparam logic [255:0] T47      = {32'h00000100, 224'h0};
    localparam logic [255:0] MISS47   = 256'h1;
    localparam logic [255:0] HIT47    = {1'b1, 255'h0};

    always #5 clk = ~clk;

    mining_job_controller dut (
        .clk                 (clk),
        .rst                 (rst),
        .job_valid           (job_valid),
        .job_ready           (job_ready),
        .job_data            (job_data),
        .max_cycles          (max_cycles),
        .abort               (abort),
        .core_enable         (core_enable),
        .core_rst            (core_rst),
        .block_without_nonce (block_without_nonce),
        .best_hash           (best_hash),
        .best_hash_nonce     (best_hash_nonce),
        .res_valid           (res_valid),
        .res_ready           (res_ready),
        .res_found           (res_found),
        .res_hash            (res_hash),
        .res_nonce           (res_nonce)
    );

    task automatic check_bit(input string name, input logic actual, input logic required);
        assertions++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, required);
        end
    endtask

    task automatic check_vec(input string name, input logic [255:0] actual, input logic [255:0] required);
        assertions++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    task automatic check_int(input string name, input int actual, input int required);
        assertions++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_job(input logic [31:0] hdr_base, input logic [255:0] target, input logic [31:0] budget);
        max_cycles = budget;
        job_valid  = 1'b1;
        for (int i = 0; i < 19; i++) begin
            job_data = hdr_base + 32'(i);
            step();
        end
        for (int j = 0; j < 8; j++) begin
            job_data = target[255-32*j -: 32];
            step();
        end
        job_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, output int cycles);
        cycles = 0;
        while (!res_valid && cycles < 1000) begin
            step();
            cycles++;
        end
        if (!res_valid) begin
            assertions++;
            failures++;
            $display("[TB] FAIL %s: res_valid timeout after %0d cycles, expected it high", name, cycles);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_bit({tag, " job_ready"}, job_ready, 1'b1);
        check_bit({tag, " core_enable"}, core_enable, 1'b0);
        check_bit({tag, " core_rst"}, core_rst, 1'b0);
        check_bit({tag, " res_valid"}, res_valid, 1'b0);
        check_bit({tag, " res_found"}, res_found, 1'b0);
        check_vec({tag, " res_hash"}, res_hash, 256'h0);
        check_vec({tag, " res_nonce"}, 256'(res_nonce), 256'h0);
        check_bit({tag, " block zero"}, block_without_nonce == '0, 1'b1);
    endtask

    // Result monitor: every handshake must match the oldest expected result.
    always @(negedge clk) begin
        result_t e;
        if (!rst && res_valid && res_ready) begin
            if (expected_q.size() == 0) begin
                assertions++;
                failures++;
                $display("[TB] FAIL unexpected result: got nonce %h, expected no result", res_nonce);
            end else begin
                e = expected_q.pop_front();
                check_bit("res_found", res_found, e.found);
                check_vec("res_hash", res_hash, e.hash);
                check_vec("res_nonce", 256'(res_nonce), 256'(e.nonce));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           cycles;
        logic [255:0] snap_hash;
        logic [31:0]  snap_nonce;
        logic         snap_found;

        rst             = 1'b1;
        job_valid       = 1'b0;
        job_data        = '0;
        max_cycles      = '0;
        abort           = 1'b0;
        res_ready       = 1'b1;
        best_hash       = '0;
        best_hash_nonce = '0;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Immediate hit on the first RUN cycle.
        best_hash       = H42;
        best_hash_nonce = 32'h42;
        expected_q.push_back('{1'b1, H42, 32'h42});
        load_job(32'h1, ALL_ONES, 32'd1000);
        check_bit("start core_rst", core_rst, 1'b1);
        check_bit("start core_enable", core_enable, 1'b1);
        check_bit("start job_ready", job_ready, 1'b0);
        check_vec("block word0", 256'(block_without_nonce[607:576]), 256'h1);
        check_vec("block word18", 256'(block_without_nonce[31:0]), 256'h13);
        step();
        check_bit("run core_rst", core_rst, 1'b0);
        check_bit("run core_enable", core_enable, 1'b1);
        check_bit("run res_valid", res_valid, 1'b0);
        step();
        check_bit("hit res_valid", res_valid, 1'b1);
        check_bit("hit core_enable", core_enable, 1'b0);
        step();
        check_bit("idle res_valid", res_valid, 1'b0);
        check_bit("idle job_ready", job_ready, 1'b1);

        // Budget exhaustion with a stalled consumer.
        res_ready       = 1'b0;
        best_hash       = H43;
        best_hash_nonce = 32'h43;
        expected_q.push_back('{1'b0, H43, 32'h43});
        load_job(32'h200, 256'h0, 32'd100);
        wait_result("budget latency", cycles);
        check_int("budget latency", cycles, 102);
        snap_hash  = res_hash;
        snap_nonce = res_nonce;
        snap_found = res_found;
        check_bit("budget res_found", res_found, 1'b0);
        best_hash       = ~H43;
        best_hash_nonce = 32'hFFFF;
        for (int k = 0; k < 20; k++) begin
            step();
            check_bit("stall res_valid", res_valid, 1'b1);
            check_bit("stall job_ready", job_ready, 1'b0);
            check_bit("stall core_enable", core_enable, 1'b0);
            check_vec("stall res_hash", res_hash, snap_hash);
            check_vec("stall res_nonce", 256'(res_nonce), 256'(snap_nonce));
            check_bit("stall res_found", res_found, snap_found);
        end
        res_ready = 1'b1;
        step();
        check_bit("post handshake res_valid", res_valid, 1'b0);
        check_bit("post handshake job_ready", job_ready, 1'b1);

        // Hit arrives on the same cycle the budget runs out.
        best_hash       = MISS47;
        best_hash_nonce = 32'h4700;
        expected_q.push_back('{1'b1, HIT47, 32'h4705});
        load_job(32'h300, T47, 32'd5);
        for (int k = 1; k <= 6; k++) begin
            step();
            check_bit("tie early res_valid", res_valid, 1'b0);
            if (k == 6) begin
                best_hash       = HIT47;
                best_hash_nonce = 32'h4705;
            end
        end
        step();
        check_bit("tie res_valid", res_valid, 1'b1);
        step();

        // Abort mid-load, then a fresh job must load from word zero.
        job_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            job_data = 32'h400 + 32'(i);
            step();
        end
        job_valid = 1'b0;
        abort     = 1'b1;
        step();
        abort = 1'b0;
        check_bit("abort job_ready", job_ready, 1'b1);
        check_bit("abort core_enable", core_enable, 1'b0);
        check_bit("abort res_valid", res_valid, 1'b0);
        best_hash       = H45;
        best_hash_nonce = 32'h45;
        expected_q.push_back('{1'b1, H45, 32'h45});
        load_job(32'h500, ALL_ONES, 32'd50);
        check_bit("reload core_rst", core_rst, 1'b1);
        check_vec("reload word0", 256'(block_without_nonce[607:576]), 256'h500);
        check_vec("reload word18", 256'(block_without_nonce[31:0]), 256'h512);
        wait_result("reload latency", cycles);
        check_int("reload latency", cycles, 2);
        step();

        // Synchronous reset in the middle of RUN.
        best_hash       = H46;
        best_hash_nonce = 32'h46;
        load_job(32'h600, 256'h0, 32'd200);
        for (int k = 0; k < 51; k++) begin
            step();
        end
        check_bit("pre-reset core_enable", core_enable, 1'b1);
        rst = 1'b1;
        step();
        check_reset_outputs("run reset");
        rst = 1'b0;
        step();
        check_bit("after reset job_ready", job_ready, 1'b1);
        check_bit("after reset res_valid", res_valid, 1'b0);

        check_int("scoreboard drained", expected_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
